// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - I2S slave receiver: oversampled SCLK/WS/SD to parallel {left,right} frames
// One-entry output holding register with sticky overrun and one-cycle framing-error pulse.
`timescale 1ns/1ps
module i2s_receiver #(
   parameter int DWIDTH   = 8,
   parameter int WS_DELAY = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                SCLK,
   input  logic                WS,
   input  logic                SD,
   output logic [2*DWIDTH-1:0] rx_data,
   output logic                rx_valid,
   input  logic                rx_ready,
   output logic                overrun,
   input  logic                ovr_clr,
   output logic                frame_err,
   output logic                locked
);

   localparam int CW = $clog2(DWIDTH + 1);
   localparam logic [CW-1:0] C_FULL = CW'(DWIDTH);
   localparam logic [CW-1:0] C_LAST = CW'(DWIDTH - 1);
   localparam logic [CW-1:0] C_ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_SYNC  = 2'd0,
      S_LEFT  = 2'd1,
      S_RIGHT = 2'd2
   } state_t;

   logic [2:0]          r_sclk_sync;
   logic [1:0]          r_ws_sync;
   logic [1:0]          r_sd_sync;
   logic                r_ws_dly;
   logic                r_ws_prev;
   state_t              r_state;
   state_t              w_state_nxt;
   logic [CW-1:0]       r_bit_cnt;
   logic [DWIDTH-1:0]   r_shift;
   logic [DWIDTH-1:0]   r_left;
   logic                r_done;
   logic [2*DWIDTH-1:0] r_frame;

   logic                w_sample;
   logic                w_ws_now;
   logic                w_sd_now;
   logic                w_ws_eff;
   logic                w_bnd_rise;
   logic                w_bnd_fall;
   logic                w_load;
   logic                w_shift;
   logic                w_done;
   logic                w_err;
   logic [DWIDTH-1:0]   w_load_val;
   logic [DWIDTH-1:0]   w_shift_nxt;
   logic [2*DWIDTH-1:0] w_frame;
   logic                w_accept;
   logic                w_ovr_set;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sclk_sync <= '0;
         r_ws_sync   <= '0;
         r_sd_sync   <= '0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[1:0], SCLK};
         r_ws_sync   <= {r_ws_sync[0], WS};
         r_sd_sync   <= {r_sd_sync[0], SD};
      end
   end

   assign w_sample   = r_sclk_sync[1] & ~r_sclk_sync[2];
   assign w_ws_now   = r_ws_sync[1];
   assign w_sd_now   = r_sd_sync[1];
   // Philips mode looks at the WS value captured one bit earlier
   assign w_ws_eff   = (WS_DELAY == 0) ? w_ws_now : r_ws_dly;
   assign w_bnd_rise = w_ws_eff & ~r_ws_prev;
   assign w_bnd_fall = ~w_ws_eff & r_ws_prev;

   assign w_load_val  = DWIDTH'(w_sd_now);
   assign w_shift_nxt = (r_shift << 1) | w_load_val;
   assign w_frame     = w_load ? {r_shift, w_load_val} : {r_left, w_shift_nxt};

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_done      = 1'b0;
      w_err       = 1'b0;
      if (w_sample) begin
         case (r_state)
            S_SYNC: begin
               if (w_bnd_fall) begin
                  w_state_nxt = S_LEFT;
                  w_load      = 1'b1;
               end
            end
            S_LEFT: begin
               if (w_bnd_rise) begin
                  if (r_bit_cnt == C_FULL) begin
                     w_state_nxt = S_RIGHT;
                     w_load      = 1'b1;
                     w_done      = (DWIDTH == 1);
                  end else begin
                     w_state_nxt = S_SYNC;
                     w_err       = 1'b1;
                  end
               end else if (r_bit_cnt != C_FULL) begin
                  w_shift = 1'b1;
               end
            end
            S_RIGHT: begin
               if (w_bnd_fall) begin
                  if (r_bit_cnt == C_FULL) begin
                     w_state_nxt = S_LEFT;
                     w_load      = 1'b1;
                  end else begin
                     w_state_nxt = S_SYNC;
                     w_err       = 1'b1;
                  end
               end else if (r_bit_cnt != C_FULL) begin
                  w_shift = 1'b1;
                  w_done  = (r_bit_cnt == C_LAST);
               end
            end
            default: w_state_nxt = S_SYNC;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_SYNC;
         r_ws_dly  <= 1'b0;
         r_ws_prev <= 1'b0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_left    <= '0;
         r_done    <= 1'b0;
         r_frame   <= '0;
         frame_err <= 1'b0;
         locked    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_done    <= w_done;
         frame_err <= w_err;
         locked    <= (r_state != S_SYNC);
         if (w_done) begin
            r_frame <= w_frame;
         end
         if (w_sample) begin
            r_ws_dly  <= w_ws_now;
            r_ws_prev <= w_ws_eff;
         end
         if (w_load) begin
            // Loading the right MSB means the left word in the shifter is final
            if (r_state == S_LEFT) begin
               r_left <= r_shift;
            end
            r_shift   <= w_load_val;
            r_bit_cnt <= C_ONE;
         end else if (w_shift) begin
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= r_bit_cnt + C_ONE;
         end else if (w_err) begin
            r_bit_cnt <= '0;
         end
      end
   end

   assign w_accept  = ~rx_valid | rx_ready;
   assign w_ovr_set = r_done & ~w_accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (r_done && w_accept) begin
            rx_data  <= r_frame;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         if (w_ovr_set) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_i2s_receiver.sv
// tb/tb_i2s_receiver.sv - directed/randomised bench for i2s_receiver
// Reference decodes the sampled WS/SD bit arrays segment by segment.
`timescale 1ns/1ps
module tb_i2s_receiver;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst, SCLK, WS, SD, rx_ready, ovr_clr;
   logic [2*DW-1:0] rx_data0, rx_data1;
   logic rx_valid0, rx_valid1, overrun0, overrun1;
   logic frame_err0, frame_err1, locked0, locked1;

   always #5 clk = ~clk;

   i2s_receiver #(.DWIDTH(DW), .WS_DELAY(0)) u_dut0 (
      .clk(clk), .rst(rst), .SCLK(SCLK), .WS(WS), .SD(SD),
      .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready),
      .overrun(overrun0), .ovr_clr(ovr_clr), .frame_err(frame_err0), .locked(locked0)
   );

   i2s_receiver #(.DWIDTH(DW), .WS_DELAY(1)) u_dut1 (
      .clk(clk), .rst(rst), .SCLK(SCLK), .WS(WS), .SD(SD),
      .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready),
      .overrun(overrun1), .ovr_clr(ovr_clr), .frame_err(frame_err1), .locked(locked1)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int n_ferr0 = 0;
   int exp_err;
   bit s_ws[$];
   bit s_sd[$];
   logic [2*DW-1:0] got0[$];
   logic [2*DW-1:0] got1[$];
   logic [2*DW-1:0] exp_q[$];
   logic lat_v[5];

   always @(negedge clk) begin
      if (rx_valid0 && rx_ready) got0.push_back(rx_data0);
      if (rx_valid1 && rx_ready) got1.push_back(rx_data1);
      if (frame_err0) n_ferr0++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_got(input string tag, input int which);
      int n;
      n = (which == 0) ? got0.size() : got1.size();
      check({tag, "_count"}, n, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s_frame%0d", tag, i), (which == 0) ? got0[i] : got1[i], exp_q[i]);
   endtask

   task automatic add_bits(input bit ws, input int n, input logic [31:0] val, input int nbits, input bit fill);
      for (int j = 0; j < n; j++) begin
         s_ws.push_back(ws);
         s_sd.push_back((j < nbits) ? val[nbits-1-j] : fill);
      end
   endtask

   task automatic add_frame(input logic [7:0] l, input logic [7:0] r, input int ls, input int rs, input bit fill);
      add_bits(1'b0, ls, {24'd0, l}, DW, fill);
      add_bits(1'b1, rs, {24'd0, r}, DW, fill);
   endtask

   function automatic logic [DW-1:0] word_at(input int p);
      logic [DW-1:0] w = '0;
      for (int j = 0; j < DW; j++) w = {w[DW-2:0], s_sd[p+j]};
      return w;
   endfunction

   // Split the effective-WS sequence into channel segments and pair them up.
   task automatic run_model(input int dly, input int start);
      int n, mode, lst, llen, rlen, st, en, len;
      bit eff[$];
      int bnd[$];
      n = s_ws.size() - start;
      exp_q.delete();
      exp_err = 0;
      for (int i = 0; i < n; i++) eff.push_back((i >= dly) ? s_ws[start+i-dly] : 1'b0);
      for (int i = 0; i < n; i++) if (eff[i] != ((i == 0) ? 1'b0 : eff[i-1])) bnd.push_back(i);
      mode = 0; lst = 0; llen = 0; rlen = 0;
      for (int k = 0; k < bnd.size(); k++) begin
         st = bnd[k];
         en = (k + 1 < bnd.size()) ? bnd[k+1] : n;
         len = en - st;
         if (!eff[st]) begin
            if (mode == 2 && rlen < DW) begin
               exp_err++; mode = 0;
            end else begin
               mode = 1; lst = st; llen = len;
            end
         end else if (mode == 1) begin
            if (llen < DW) begin
               exp_err++; mode = 0;
            end else begin
               mode = 2; rlen = len;
               if (len >= DW) exp_q.push_back({word_at(start+lst), word_at(start+st)});
            end
         end
      end
   endtask

   task automatic send_bit(input bit ws, input bit sd);
      SCLK = 1'b0; WS = ws; SD = sd;
      repeat (4) @(posedge clk);
      #1 SCLK = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         lat_v[k] = rx_valid0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic play(input int from, input int to);
      for (int i = from; i < to; i++) send_bit(s_ws[i], s_sd[i]);
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      s_ws.delete(); s_sd.delete(); got0.delete(); got1.delete();
      n_ferr0 = 0;
   endtask

   initial begin
      rst = 1'b1; SCLK = 1'b0; WS = 1'b1; SD = 1'b0; rx_ready = 1'b1; ovr_clr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_data", rx_data0, 0);
      check("rst_valid", rx_valid0, 0);
      check("rst_overrun", overrun0, 0);
      check("rst_frame_err", frame_err0, 0);
      check("rst_locked", locked0, 0);
      @(posedge clk); #1 rst = 1'b0;

      // single frame, latency and lock
      s_ws.delete(); s_sd.delete(); got0.delete(); got1.delete(); n_ferr0 = 0;
      add_bits(1'b1, 2, 0, 0, 1'b0);
      add_frame(8'hA5, 8'h3C, DW, DW, 1'b0);
      add_bits(1'b0, 2, 0, 0, 1'b0);
      run_model(0, 0);
      play(0, 2);
      check("t1_unlocked_idle", locked0, 0);
      play(2, 3);
      check("t1_locked_msb", locked0, 1);
      play(3, 18);
      check("t1_lat_edge2", lat_v[3], 0);
      check("t1_lat_edge3", lat_v[4], 1);
      play(18, s_ws.size());
      settle(6);
      check_got("t1", 0);
      check("t1_value", got0[0], 16'hA53C);
      check("t1_frame_err", n_ferr0, exp_err);

      // overrun with a stalled consumer
      do_reset();
      rx_ready = 1'b0;
      add_bits(1'b1, 2, 0, 0, 1'b0);
      add_frame(8'h12, 8'h34, DW, DW, 1'b0);
      add_frame(8'h56, 8'h78, DW, DW, 1'b0);
      add_bits(1'b0, 2, 0, 0, 1'b0);
      run_model(0, 0);
      play(0, s_ws.size());
      settle(6);
      @(negedge clk);
      check("t2_valid_held", rx_valid0, 1);
      check("t2_data_held", rx_data0, exp_q[0]);
      check("t2_data_const", rx_data0, 16'h1234);
      check("t2_overrun", overrun0, (exp_q.size() > 1));
      @(posedge clk); #1 rx_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("t2_valid_consumed", rx_valid0, 0);
      check("t2_consumed_count", got0.size(), 1);
      check("t2_consumed_value", got0[0], exp_q[0]);
      @(posedge clk); #1 ovr_clr = 1'b1;
      @(posedge clk); #1 ovr_clr = 1'b0;
      @(negedge clk);
      check("t2_ovr_cleared", overrun0, 0);

      // short left channel
      do_reset();
      add_bits(1'b1, 2, 0, 0, 1'b0);
      add_bits(1'b0, 5, $urandom_range(0, 31), 5, 1'b0);
      add_bits(1'b1, DW, $urandom_range(0, 255), DW, 1'b0);
      add_frame(8'h0F, 8'hF0, DW, DW, 1'b0);
      add_bits(1'b0, 2, 0, 0, 1'b0);
      run_model(0, 0);
      play(0, 8);
      settle(2);
      check("t3_err_pulses", n_ferr0, 1);
      check("t3_unlocked", locked0, 0);
      check("t3_no_valid", got0.size(), 0);
      play(8, s_ws.size());
      settle(6);
      check_got("t3", 0);
      check("t3_value", got0[0], 16'h0FF0);
      check("t3_err_total", n_ferr0, exp_err);

      // Philips framing seen by both instances
      do_reset();
      add_bits(1'b1, 2, 0, 0, 1'b0);
      add_frame(8'h80, 8'h01, DW, DW, 1'b0);
      add_bits(1'b0, 2, 0, 0, 1'b0);
      s_sd.push_front(1'b0);
      void'(s_sd.pop_back());
      play(0, s_ws.size());
      settle(6);
      run_model(1, 0);
      check_got("t4_philips", 1);
      check("t4_philips_value", got1[0], 16'h8001);
      run_model(0, 0);
      check_got("t4_lj", 0);
      check("t4_lj_differs", (got0[0] != 16'h8001), 1);

      // wide slots, back-to-back random frames
      do_reset();
      add_bits(1'b1, 2, 0, 0, 1'b0);
      add_frame(8'hC3, 8'h5A, 12, 12, 1'b1);
      for (int f = 0; f < 5; f++)
         add_frame(8'($urandom), 8'($urandom), $urandom_range(8, 12), $urandom_range(8, 12), 1'($urandom));
      add_bits(1'b0, 2, 0, 0, 1'b0);
      run_model(0, 0);
      play(0, s_ws.size());
      settle(6);
      check_got("t5", 0);
      check("t5_first", got0[0], 16'hC35A);
      check("t5_no_overrun", overrun0, 0);
      check("t5_frame_err", n_ferr0, exp_err);

      // reset in the middle of a right channel
      do_reset();
      rx_ready = 1'b0;
      add_bits(1'b1, 2, 0, 0, 1'b0);
      add_frame(8'($urandom), 8'($urandom), DW, DW, 1'b0);
      add_frame(8'($urandom), 8'($urandom), DW, DW, 1'b0);
      add_frame(8'hBE, 8'hEF, DW, DW, 1'b0);
      add_bits(1'b0, 2, 0, 0, 1'b0);
      play(0, 30);
      check("t6_held_before", rx_valid0, 1);
      @(posedge clk); #1 rst = 1'b1;
      #1;
      check("t6_rst_valid", rx_valid0, 0);
      check("t6_rst_data", rx_data0, 0);
      check("t6_rst_locked", locked0, 0);
      check("t6_rst_overrun", overrun0, 0);
      @(posedge clk); #1 rst = 1'b0;
      rx_ready = 1'b1;
      got0.delete();
      n_ferr0 = 0;
      run_model(0, 30);
      play(30, s_ws.size());
      settle(6);
      check_got("t6", 0);
      check("t6_value", got0[0], 16'hBEEF);
      check("t6_frame_err", n_ferr0, exp_err);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
